// File: rtl/lut_seq_pkg.sv
// Shared types, derived sizes and the table-address packing helper for the
// LUT layer sequencer.
package lut_seq_pkg;
    localparam int NUM_NEURONS = 8;
    localparam int FANIN       = 3;
    localparam int IN_BITS     = 2;
    localparam int OUT_BITS    = 2;
    localparam int IN_WIDTH    = 32;

    localparam int ADDR_W      = FANIN * IN_BITS;
    localparam int FEATURES    = IN_WIDTH / IN_BITS;
    localparam int FEAT_IDX_W  = $clog2(FEATURES);
    localparam int NEURON_W    = $clog2(NUM_NEURONS);
    localparam int OUT_W       = NUM_NEURONS * OUT_BITS;
    localparam int RAM_AW      = NEURON_W + ADDR_W;
    localparam int CONN_N      = NUM_NEURONS * FANIN;
    localparam int CONN_AW     = $clog2(CONN_N);

    localparam logic [NEURON_W:0]   NEURON_LIMIT = (NEURON_W+1)'(NUM_NEURONS);
    localparam logic [ADDR_W-1:0]   SLOT_LIMIT   = ADDR_W'(FANIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    // Slot 0 lands in the address LSBs.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [IN_WIDTH-1:0]         feats,
        input logic [FANIN*FEAT_IDX_W-1:0] sel
    );
        logic [ADDR_W-1:0] a;
        int f;
        a = '0;
        for (int s = 0; s < FANIN; s++) begin
            f = int'(sel[s*FEAT_IDX_W +: FEAT_IDX_W]);
            a[s*IN_BITS +: IN_BITS] = feats[f*IN_BITS +: IN_BITS];
        end
        return a;
    endfunction
endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Stream, config and debug signals of the LUT layer sequencer.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender keeps valid and data stable until that edge, ready may change freely.
interface lut_layer_sequencer_if import lut_seq_pkg::*; ;
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  busy;
    logic                  cfg_tt_we;
    logic                  cfg_conn_we;
    logic [NEURON_W:0]     cfg_neuron;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [FEAT_IDX_W-1:0] cfg_data;
    logic                  cfg_err;
    state_t                dbg_state;

    modport master (
        output in_valid, in_data, out_ready,
        output cfg_tt_we, cfg_conn_we, cfg_neuron, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, busy, cfg_err, dbg_state
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  cfg_tt_we, cfg_conn_we, cfg_neuron, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, busy, cfg_err, dbg_state
    );
endinterface

// File: rtl/lut_table_ram.sv
// Truth-table storage shared by all neurons: one write port, one synchronous
// read port, contents are not reset.
module lut_table_ram import lut_seq_pkg::*; (
    input  logic                clk,
    input  logic                we,
    input  logic [RAM_AW-1:0]   waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [RAM_AW-1:0]   raddr,
    output logic [OUT_BITS-1:0] rdata
);
    logic [OUT_BITS-1:0] mem [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one LogicNets layer: each neuron takes an
// ADDR cycle (gather features, issue read) and a READ cycle (pack result).
module lut_layer_sequencer import lut_seq_pkg::*; (
    input logic             clk,
    input logic             rst_n,
    lut_layer_sequencer_if.slave bus
);
    state_t                      state, state_nxt;
    logic [NEURON_W-1:0]         n, n_nxt;
    logic [IN_WIDTH-1:0]         feat_q;
    logic [FEAT_IDX_W-1:0]       conn [CONN_N];
    logic [FANIN*FEAT_IDX_W-1:0] conn_sel;
    logic [ADDR_W-1:0]           tt_addr;
    logic [OUT_BITS-1:0]         ram_rdata;
    logic [OUT_W-1:0]            out_q;
    logic [CONN_AW-1:0]          conn_widx;
    logic                        accept, last;
    logic                        cfg_req, cfg_ok, tt_wr, conn_wr;
    logic                        cfg_err_q;

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = rst_n && (state == DONE);
    assign bus.busy      = rst_n && (state != IDLE);
    assign bus.out_data  = out_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.dbg_state = state;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (n == NEURON_W'(NUM_NEURONS - 1));

    // Writes are legal only in IDLE, so the RAM never sees a read/write clash.
    assign cfg_req = bus.cfg_tt_we || bus.cfg_conn_we;
    assign cfg_ok  = rst_n && (state == IDLE)
                     && (bus.cfg_tt_we ^ bus.cfg_conn_we)
                     && (bus.cfg_neuron < NEURON_LIMIT)
                     && (!bus.cfg_conn_we || (bus.cfg_addr < SLOT_LIMIT));
    assign tt_wr   = cfg_ok && bus.cfg_tt_we;
    assign conn_wr = cfg_ok && bus.cfg_conn_we;
    assign conn_widx = CONN_AW'(int'(bus.cfg_neuron[NEURON_W-1:0]) * FANIN
                                + int'(bus.cfg_addr));

    always_comb begin
        conn_sel = '0;
        for (int s = 0; s < FANIN; s++) begin
            conn_sel[s*FEAT_IDX_W +: FEAT_IDX_W] = conn[CONN_AW'(int'(n) * FANIN + s)];
        end
    end

    assign tt_addr = pack_addr(feat_q, conn_sel);

    lut_table_ram u_ram (
        .clk   (clk),
        .we    (tt_wr),
        .waddr ({bus.cfg_neuron[NEURON_W-1:0], bus.cfg_addr}),
        .wdata (bus.cfg_data[OUT_BITS-1:0]),
        .raddr ({n, tt_addr}),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ADDR;
                    n_nxt     = '0;
                end
            end
            ADDR: state_nxt = READ;
            READ: begin
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = ADDR;
                    n_nxt     = n + NEURON_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            n     <= '0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_req && !cfg_ok;
            if (state == READ) begin
                out_q[n*OUT_BITS +: OUT_BITS] <= ram_rdata;
            end
        end
    end

    // Captured vector and connectivity survive reset; only valid data is consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            feat_q <= bus.in_data;
        end
        if (conn_wr) begin
            conn[conn_widx] <= bus.cfg_data;
        end
    end
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer: reset, table evaluation, backpressure,
// config rejection, same-cycle config+input and mid-evaluation reset.
module tb_lut_layer_sequencer;
    import lut_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [1:0]       tt_m   [NUM_NEURONS][64];
    logic [3:0]       conn_m [NUM_NEURONS][FANIN];
    logic [OUT_W-1:0] exp_q[$];

    lut_layer_sequencer_if bus();

    lut_layer_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [OUT_W-1:0] model(input logic [IN_WIDTH-1:0] d);
        logic [OUT_W-1:0] e;
        logic [5:0] a;
        int f;
        e = '0;
        for (int nn = 0; nn < NUM_NEURONS; nn++) begin
            a = '0;
            for (int s = 0; s < FANIN; s++) begin
                f = int'(conn_m[nn][s]);
                a[s*2 +: 2] = d[f*2 +: 2];
            end
            e[nn*2 +: 2] = tt_m[nn][a];
        end
        return e;
    endfunction

    task automatic cfg_write(input logic tt, input logic cn, input int nn, input int a, input int d);
        @(negedge clk);
        bus.cfg_tt_we = tt; bus.cfg_conn_we = cn;
        bus.cfg_neuron = 4'(nn); bus.cfg_addr = 6'(a); bus.cfg_data = 4'(d);
        @(negedge clk);
        bus.cfg_tt_we = 1'b0; bus.cfg_conn_we = 1'b0;
    endtask

    task automatic load_tt(input int nn, input int a, input int d);
        cfg_write(1'b1, 1'b0, nn, a, d);
        tt_m[nn][a] = 2'(d);
    endtask

    task automatic load_conn(input int nn, input int s, input int f);
        cfg_write(1'b0, 1'b1, nn, s, f);
        conn_m[nn][s] = 4'(f);
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic send(input logic [IN_WIDTH-1:0] d);
        int i;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d;
        i = 0;
        while (!bus.in_ready && i < 50) begin @(negedge clk); i++; end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_timeout: in_ready=%b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // lat counts cycles after the accept edge, the first such cycle being 1.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin @(negedge clk); lat++; end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL out_timeout: out_valid=%b want 1", bus.out_valid); end
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input logic [IN_WIDTH-1:0] d, output int lat, output logic [OUT_W-1:0] got);
        send(d);
        wait_out(lat);
        got = bus.out_data;
        take_out();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
            n_checks++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
            n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_err: got %b want 0", bus.cfg_err); end
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        n_checks++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL rel_no_capture: state %0d want IDLE", bus.dbg_state); end
    endtask

    task automatic test_identity();
        int lat;
        logic [OUT_W-1:0] got;
        logic [IN_WIDTH-1:0] vecs [3];
        vecs[0] = 32'hE4E4E4E4; vecs[1] = 32'h1B1B1B1B; vecs[2] = 32'h00000000;
        for (int nn = 0; nn < NUM_NEURONS; nn++) begin
            for (int a = 0; a < 64; a++) load_tt(nn, a, (a & 3) ^ (nn & 3));
            for (int s = 0; s < FANIN; s++) load_conn(nn, s, nn + s);
        end
        n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL legal_cfg_err: got %b want 0", bus.cfg_err); end
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hE4E4);
        for (int v = 0; v < 3; v++) begin
            run_vec(vecs[v], lat, got);
            n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL ident_latency[%0d]: got %0d want 17", v, lat); end
            n_checks++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL ident_data[%0d]: got %h want %h", v, got, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_mixed();
        int lat;
        logic [OUT_W-1:0] got;
        logic [IN_WIDTH-1:0] vecs [2];
        vecs[0] = 32'h9C3A5F17; vecs[1] = 32'h5A5AC3F0;
        for (int a = 0; a < 64; a++) begin
            load_tt(1, a, (a & 3) ^ ((a >> 4) & 3));
            load_tt(2, a, (((a >> 2) & 3) + ((a >> 4) & 3)) & 3);
        end
        load_conn(1, 0, 3); load_conn(1, 1, 7); load_conn(1, 2, 15);
        load_conn(2, 0, 1); load_conn(2, 1, 6); load_conn(2, 2, 12);
        for (int v = 0; v < 2; v++) begin
            exp_q.push_back(model(vecs[v]));
            run_vec(vecs[v], lat, got);
            n_checks++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL mixed_data[%0d]: got %h want %h", v, got, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [OUT_W-1:0] e1, e2;
        e1 = model(32'h9C3A5F17);
        e2 = model(32'h00000000);
        send(32'h9C3A5F17);
        wait_out(lat);
        bus.in_valid = 1'b1; bus.in_data = 32'h00000000;
        repeat (10) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
            n_checks++; if (bus.out_data !== e1) begin n_fail++; $display("FAIL bp_stable: got %h want %h", bus.out_data, e1); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        end
        take_out();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++; if (bus.dbg_state !== ADDR) begin n_fail++; $display("FAIL bp_second_accept: state %0d want ADDR", bus.dbg_state); end
        wait_out(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL bp_latency: got %0d want 17", lat); end
        n_checks++; if (bus.out_data !== e2) begin n_fail++; $display("FAIL bp_second_data: got %h want %h", bus.out_data, e2); end
        take_out();
    endtask

    task automatic test_cfg_reject();
        int lat;
        logic [OUT_W-1:0] got, e;
        e = model(32'hE4E4E4E4);
        send(32'hE4E4E4E4);
        cfg_write(1'b1, 1'b0, 0, 36, 3);
        n_checks++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_busy: cfg_err %b want 1", bus.cfg_err); end
        @(negedge clk);
        n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL rej_pulse: cfg_err %b want 0", bus.cfg_err); end
        wait_out(lat);
        n_checks++; if (bus.out_data !== e) begin n_fail++; $display("FAIL rej_busy_data: got %h want %h", bus.out_data, e); end
        take_out();
        cfg_write(1'b1, 1'b0, 8, 36, 3);
        n_checks++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_neuron: cfg_err %b want 1", bus.cfg_err); end
        cfg_write(1'b0, 1'b1, 0, 3, 0);
        n_checks++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_slot: cfg_err %b want 1", bus.cfg_err); end
        cfg_write(1'b1, 1'b1, 0, 36, 3);
        n_checks++; if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_both: cfg_err %b want 1", bus.cfg_err); end
        run_vec(32'hE4E4E4E4, lat, got);
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL rej_after_a: got %h want %h", got, e); end
        e = model(32'h9C3A5F17);
        run_vec(32'h9C3A5F17, lat, got);
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL rej_after_b: got %h want %h", got, e); end
    endtask

    task automatic test_same_cycle();
        int lat;
        logic [OUT_W-1:0] e;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'hE4E4E4E4;
        bus.cfg_tt_we = 1'b1; bus.cfg_neuron = 4'd0; bus.cfg_addr = 6'd36; bus.cfg_data = 4'd3;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.cfg_tt_we = 1'b0;
        tt_m[0][36] = 2'b11;
        e = model(32'hE4E4E4E4);
        n_checks++; if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL same_cfg_err: got %b want 0", bus.cfg_err); end
        n_checks++; if (bus.dbg_state !== ADDR) begin n_fail++; $display("FAIL same_accept: state %0d want ADDR", bus.dbg_state); end
        wait_out(lat);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL same_latency: got %0d want 17", lat); end
        n_checks++; if (bus.out_data[1:0] !== 2'b11) begin n_fail++; $display("FAIL same_n0: got %b want 11", bus.out_data[1:0]); end
        n_checks++; if (bus.out_data !== e) begin n_fail++; $display("FAIL same_data: got %h want %h", bus.out_data, e); end
        take_out();
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen;
        logic [OUT_W-1:0] got, e;
        send(32'h9C3A5F17);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL mid_out_data: got %h want 0000", bus.out_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL mid_idle: state %0d want IDLE", bus.dbg_state); end
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_output: out_valid high %0d cycles want 0", seen); end
        e = model(32'h5A5AC3F0);
        run_vec(32'h5A5AC3F0, lat, got);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL mid_next_latency: got %0d want 17", lat); end
        n_checks++; if (got !== e) begin n_fail++; $display("FAIL mid_next_data: got %h want %h", got, e); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.cfg_tt_we = 1'b0; bus.cfg_conn_we = 1'b0;
        bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
        test_reset();
        test_identity();
        test_mixed();
        test_backpressure();
        test_cfg_reject();
        test_same_cycle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lut_layer_sequencer.md
# lut_layer_sequencer

Time-multiplexed evaluator for one LogicNets layer of truth-table neurons: one synchronous-read truth-table RAM is shared across all NUM_NEURONS neurons instead of instantiating one ROM per neuron. Per neuron it gathers the FANIN selected features from a captured input vector, forms a 6-bit table address, reads a 2-bit result and packs it into the layer output word. Truth tables and connectivity are loaded at runtime through a config port, which is accepted only while idle. Sits between adjacent layer registers in the classifier pipeline, with valid/ready on both sides.

## Interface
- NUM_NEURONS, 8, neurons evaluated per input vector (power of 2, 2..64)
- FANIN, 3, selected inputs per neuron
- IN_BITS, 2, bits per feature; table address width ADDR_W = FANIN*IN_BITS = 6
- OUT_BITS, 2, bits per neuron output
- IN_WIDTH, 32, input vector width; FEATURES = IN_WIDTH/IN_BITS = 16 (power of 2)
- clk  in  1  the single clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_data  in  IN_WIDTH  feature vector; feature f = in_data[f*IN_BITS +: IN_BITS]
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_data  out  NUM_NEURONS*OUT_BITS  neuron n at [n*OUT_BITS +: OUT_BITS]
- busy  out  1  high in any state other than IDLE
- cfg_tt_we  in  1  truth-table write strobe
- cfg_conn_we  in  1  connectivity write strobe
- cfg_neuron  in  $clog2(NUM_NEURONS)+1  target neuron (MSB allows out-of-range detection)
- cfg_addr  in  ADDR_W  table address (tt write) or slot index in low bits (conn write)
- cfg_data  in  $clog2(FEATURES)  table entry in low OUT_BITS bits, or feature index
- cfg_err  out  1  one-cycle pulse: config write rejected

## Operation
- States: IDLE, ADDR, READ, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data, set n=0, go to ADDR.
- ADDR: addr = {feat[conn[n][FANIN-1]], …, feat[conn[n][0]]}, slot 0 in the LSBs; present {n, addr} to the RAM; go to READ.
- READ: write the RAM output into slot n of out_data. If n == NUM_NEURONS-1, go to DONE; else n++ and go to ADDR.
- DONE: out_valid=1, out_data stable. On out_ready, go to IDLE. in_ready stays 0 until IDLE is re-entered.
- Config writes are accepted only in IDLE, with exactly one of cfg_tt_we/cfg_conn_we high.
  - Rejected with a cfg_err pulse, no state change, if: both strobes high, busy, cfg_neuron >= NUM_NEURONS, or conn slot >= FANIN.
  - A config write and an input handshake in the same IDLE cycle are both accepted. The write commits before the first ADDR, so the new entry is used.
- Truth-table RAM and connectivity contents are not cleared by reset and are undefined until loaded.
- out_data is not cleared between vectors. Slots are overwritten as neurons are evaluated.

## Timing
- While rst_n is low at a clock edge:
  - next state IDLE, n=0
  - in_ready=0, out_valid=0, busy=0, cfg_err=0, out_data=0
- First cycle after reset: in_ready=1.
- Reset mid-evaluation or in DONE aborts the evaluation; the pending output is lost.
- Input accepted at edge T: ADDR for neuron n in cycle T+1+2n, READ in cycle T+2+2n.
- out_valid rises at T+1+2*NUM_NEURONS (T+17 for 8 neurons).
- Throughput: one vector per 2*NUM_NEURONS+2 cycles when out_ready is held high.
- RAM: one-cycle synchronous read; write port used only in IDLE, so read and write never collide.
- cfg_err is asserted in the cycle after the rejected request.
- out_valid holds until out_ready is sampled high; out_data must not change while out_valid=1.

## Structure
- Package lut_seq_pkg holds:
  - the state enum
  - derived localparams ADDR_W, FEATURES, FEAT_IDX_W, NEURON_W
  - an address-pack helper function
- Sub-module lut_table_ram: NUM_NEURONS*2^ADDR_W x OUT_BITS, one write port, one synchronous read port, no reset.
- Connectivity is a register array of NUM_NEURONS*FANIN x FEAT_IDX_W held in the top level, with no reset.

## Test plan
- Reset: hold rst_n low 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, no capture; in_ready=1 on the first cycle after release.
- Identity load: load neuron n table as entry(a) = a[1:0] ^ n[1:0], conn[n] = {n+2, n+1, n}; send in_data=32'hE4E4E4E4 -> out_valid exactly 17 cycles after accept, out_data matches the model for all 8 neurons.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0, second vector accepted the cycle after the output handshake.
- Config rejection: tt write during busy, cfg_neuron=8, conn slot=3, and both strobes high -> cfg_err pulses each time; a following vector gives unchanged results.
- Same-cycle config + input: in IDLE, write neuron 0 entry at the address the next vector produces, changing 00->11, together with in_valid -> out_data[1:0]=2'b11.
- Mid-operation reset: assert rst_n low at cycle T+7 -> out_valid never rises for that vector, IDLE on release; the next vector is evaluated correctly with the tables retained.
